// File: rtl/memory_types_pkg.sv
// Shared memory-port types: request/response packet and request source ID.
package memory_types_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              we;
    } mem_pkt_t;

    typedef enum logic {
        SRC_IMEM,
        SRC_DMEM
    } mem_src_t;

    // Source that wins a contested cycle, given the last accepted source.
    function automatic mem_src_t rr_other(input mem_src_t last);
        return (last == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_src_fifo.sv
// In-order record of which port issued each accepted request.
module src_fifo
    import memory_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  mem_src_t         src_i,
    input  logic             pop_i,
    output mem_src_t         head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    mem_src_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Next-state: pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        full_o  = (count_q == CNT_W'(DEPTH));
        empty_o = (count_q == '0);
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wptr_d  = wptr_q + PTR_W'(do_push);
        rptr_d  = rptr_q + PTR_W'(do_pop);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        head_o  = mem_q[rptr_q];
        count_o = count_q;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= SRC_IMEM;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push) begin
                mem_q[wptr_q] <= src_i;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port between imem and dmem, with in-order
// response routing back to the issuing port. No added latency on either path.
module mem_port_arbiter
    import memory_types_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_req_vld,
    output logic             imem_req_rdy,
    input  mem_pkt_t         imem_req,
    output logic             imem_rsp_vld,
    input  logic             imem_rsp_rdy,
    output mem_pkt_t         imem_rsp,
    input  logic             dmem_req_vld,
    output logic             dmem_req_rdy,
    input  mem_pkt_t         dmem_req,
    output logic             dmem_rsp_vld,
    input  logic             dmem_rsp_rdy,
    output mem_pkt_t         dmem_rsp,
    output logic             mem_req_vld,
    input  logic             mem_req_rdy,
    output mem_pkt_t         mem_req,
    input  logic             mem_rsp_vld,
    output logic             mem_rsp_rdy,
    input  mem_pkt_t         mem_rsp,
    output logic [CNT_W-1:0] outstanding,
    output logic             rsp_err
);

    mem_src_t         rr_last_q, rr_last_d;
    mem_src_t         winner;
    mem_src_t         head;
    logic             rsp_err_q, rsp_err_d;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] count;
    logic             win_vld, slot_free, can_issue, accept, rsp_pop;

    src_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_src_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (accept),
        .src_i   (winner),
        .pop_i   (rsp_pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // Request grant and mux; rr_last only advances on an accepted request.
    always_comb begin
        winner = rr_other(rr_last_q);
        if (imem_req_vld && !dmem_req_vld) begin
            winner = SRC_IMEM;
        end else if (dmem_req_vld && !imem_req_vld) begin
            winner = SRC_DMEM;
        end
        win_vld   = (winner == SRC_IMEM) ? imem_req_vld : dmem_req_vld;
        slot_free = (count < CNT_W'(MAX_OUTSTANDING));
        can_issue = mem_req_rdy & slot_free;
        // Valid is withheld when full so downstream never accepts an untracked request.
        mem_req_vld  = rst_n & win_vld & slot_free;
        mem_req      = (winner == SRC_IMEM) ? imem_req : dmem_req;
        imem_req_rdy = rst_n & can_issue & (winner == SRC_IMEM);
        dmem_req_rdy = rst_n & can_issue & (winner == SRC_DMEM);
        accept       = mem_req_vld & mem_req_rdy;
        rr_last_d    = accept ? winner : rr_last_q;
    end

    // Response demux by FIFO head; a response with nothing outstanding is drained.
    always_comb begin
        imem_rsp     = mem_rsp;
        dmem_rsp     = mem_rsp;
        imem_rsp_vld = 1'b0;
        dmem_rsp_vld = 1'b0;
        mem_rsp_rdy  = rst_n;
        if (!fifo_empty) begin
            if (head == SRC_IMEM) begin
                imem_rsp_vld = rst_n & mem_rsp_vld;
                mem_rsp_rdy  = rst_n & imem_rsp_rdy;
            end else begin
                dmem_rsp_vld = rst_n & mem_rsp_vld;
                mem_rsp_rdy  = rst_n & dmem_rsp_rdy;
            end
        end
        rsp_pop     = mem_rsp_vld & mem_rsp_rdy & ~fifo_empty;
        rsp_err_d   = rsp_err_q | (mem_rsp_vld & fifo_empty);
        outstanding = count;
        rsp_err     = rsp_err_q;
    end

    // Arbitration history and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= SRC_IMEM;
            rsp_err_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
            rsp_err_q <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_OUTSTANDING = 4).
module tb_mem_port_arbiter;
    import memory_types_pkg::*;

    localparam int unsigned MaxOut = 4;
    localparam int unsigned CntW   = $clog2(MaxOut) + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req_vld, imem_req_rdy, imem_rsp_vld, imem_rsp_rdy;
    logic            dmem_req_vld, dmem_req_rdy, dmem_rsp_vld, dmem_rsp_rdy;
    logic            mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
    mem_pkt_t        imem_req, imem_rsp, dmem_req, dmem_rsp, mem_req, mem_rsp;
    logic [CntW-1:0] outstanding;
    logic            rsp_err;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .MAX_OUTSTANDING (MaxOut),
        .CNT_W           (CntW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_vld (imem_req_vld),
        .imem_req_rdy (imem_req_rdy),
        .imem_req     (imem_req),
        .imem_rsp_vld (imem_rsp_vld),
        .imem_rsp_rdy (imem_rsp_rdy),
        .imem_rsp     (imem_rsp),
        .dmem_req_vld (dmem_req_vld),
        .dmem_req_rdy (dmem_req_rdy),
        .dmem_req     (dmem_req),
        .dmem_rsp_vld (dmem_rsp_vld),
        .dmem_rsp_rdy (dmem_rsp_rdy),
        .dmem_rsp     (dmem_rsp),
        .mem_req_vld  (mem_req_vld),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req      (mem_req),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_rdy  (mem_rsp_rdy),
        .mem_rsp      (mem_rsp),
        .outstanding  (outstanding),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic mem_pkt_t mk(input logic [31:0] addr, input logic [31:0] data);
        mem_pkt_t p;
        p.addr = addr;
        p.data = data;
        p.we   = 1'b0;
        return p;
    endfunction

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_vld = 1'b0;
        dmem_req_vld = 1'b0;
        imem_req     = mk(32'h0, 32'h0);
        dmem_req     = mk(32'h0, 32'h0);
        imem_rsp_rdy = 1'b1;
        dmem_rsp_rdy = 1'b1;
        mem_req_rdy  = 1'b1;
        mem_rsp_vld  = 1'b0;
        mem_rsp      = mk(32'h0, 32'h0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2;
        do_reset();
        #1;
        check_eq("reset_outstanding", outstanding, 0);
        check_eq("reset_rsp_err", rsp_err, 0);
        check_eq("reset_mem_req_vld", mem_req_vld, 0);

        // imem-only stream, responses two cycles after each request.
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            imem_req_vld = (c < 4);
            imem_req     = mk(32'(4 * c), 32'h0);
            mem_rsp_vld  = (c >= 2 && c < 6);
            mem_rsp      = mk(32'(4 * (c - 2)), 32'(32'h100 + c - 2));
            #1;
            if (c == 0) check_eq("t1_out_c0", outstanding, 0);
            if (c == 1) check_eq("t1_out_c1", outstanding, 1);
            if (c == 3) check_eq("t1_out_peak", outstanding, 2);
            if (c == 5) check_eq("t1_out_c5", outstanding, 1);
            if (c == 6) check_eq("t1_out_c6", outstanding, 0);
            if (c < 4) begin
                check_eq("t1_imem_rdy", imem_req_rdy, 1);
                check_eq("t1_mem_req_addr", mem_req.addr, 32'(4 * c));
            end
            if (c >= 2 && c < 6) begin
                check_eq("t1_imem_rsp_vld", imem_rsp_vld, 1);
                check_eq("t1_imem_rsp", imem_rsp, mk(32'(4 * (c - 2)), 32'(32'h100 + c - 2)));
            end
            check_eq("t1_dmem_rsp_vld", dmem_rsp_vld, 0);
        end

        // Both ports contend every cycle: D,I,D,I; responses one cycle later.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            imem_req_vld = (c < 4);
            dmem_req_vld = (c < 4);
            imem_req     = mk(32'(32'h1000 + 4 * c), 32'h0);
            dmem_req     = mk(32'(32'h2000 + 4 * c), 32'h0);
            mem_rsp_vld  = (c >= 1 && c <= 4);
            mem_rsp      = mk(32'h0, 32'(32'hA0 + c));
            #1;
            if (c < 4) begin
                check_eq("t2_dmem_rdy", dmem_req_rdy, (c % 2 == 0));
                check_eq("t2_imem_rdy", imem_req_rdy, (c % 2 == 1));
                check_eq("t2_mem_req_addr", mem_req.addr,
                         (c % 2 == 0) ? 32'(32'h2000 + 4 * c) : 32'(32'h1000 + 4 * c));
            end
            if (c >= 1 && c <= 4) begin
                check_eq("t2_dmem_rsp_vld", dmem_rsp_vld, (c % 2 == 1));
                check_eq("t2_imem_rsp_vld", imem_rsp_vld, (c % 2 == 0));
            end
            if (c == 2) check_eq("t2_out_mid", outstanding, 1);
            if (c == 5) check_eq("t2_out_end", outstanding, 0);
        end

        // Fill to MAX_OUTSTANDING with no responses; a pop does not relieve full.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            imem_req_vld = 1'b1;
            dmem_req_vld = 1'b1;
            mem_rsp_vld  = (c == 4);
            mem_rsp      = mk(32'h0, 32'h55);
            #1;
            if (c == 4) begin
                check_eq("t3_full_out", outstanding, 4);
                check_eq("t3_full_imem_rdy", imem_req_rdy, 0);
                check_eq("t3_full_dmem_rdy", dmem_req_rdy, 0);
                check_eq("t3_rsp_to_dmem", dmem_rsp_vld, 1);
                check_eq("t3_mem_rsp_rdy", mem_rsp_rdy, 1);
            end
            if (c == 5) begin
                check_eq("t3_after_pop_out", outstanding, 3);
                check_eq("t3_regrant_dmem", dmem_req_rdy, 1);
                check_eq("t3_regrant_imem", imem_req_rdy, 0);
            end
            if (c == 6) begin
                check_eq("t3_refull_out", outstanding, 4);
                check_eq("t3_refull_rdy", dmem_req_rdy, 0);
            end
        end

        // Downstream stall: dmem holds the grant while imem arrives.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            dmem_req_vld = (c < 4);
            dmem_req     = mk(32'h3000, 32'hD0);
            imem_req_vld = (c >= 1);
            imem_req     = mk(32'h4000, 32'h10);
            mem_req_rdy  = (c >= 3);
            #1;
            if (c < 3) begin
                check_eq("t4_stall_dmem_rdy", dmem_req_rdy, 0);
                check_eq("t4_stall_pkt", mem_req, mk(32'h3000, 32'hD0));
                check_eq("t4_stall_imem_rdy", imem_req_rdy, 0);
            end
            if (c == 3) check_eq("t4_dmem_accept", dmem_req_rdy, 1);
            if (c == 4) begin
                check_eq("t4_out_after", outstanding, 1);
                check_eq("t4_imem_next", imem_req_rdy, 1);
            end
        end

        // Orphan response: drained, flagged, never forwarded.
        do_reset();
        next_cycle();
        mem_rsp_vld = 1'b1;
        #1;
        check_eq("t5_drop_rdy", mem_rsp_rdy, 1);
        check_eq("t5_no_imem_vld", imem_rsp_vld, 0);
        check_eq("t5_no_dmem_vld", dmem_rsp_vld, 0);
        check_eq("t5_err_before", rsp_err, 0);
        next_cycle();
        mem_rsp_vld = 1'b0;
        #1;
        check_eq("t5_err_set", rsp_err, 1);
        check_eq("t5_out_zero", outstanding, 0);
        next_cycle();
        next_cycle();
        check_eq("t5_err_sticky", rsp_err, 1);

        // Async reset with 3 outstanding.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            imem_req_vld = 1'b1;
            imem_req     = mk(32'(32'h5000 + 4 * c), 32'h0);
        end
        next_cycle();
        imem_req_vld = 1'b1;
        dmem_req_vld = 1'b1;
        mem_req_rdy  = 1'b0;
        mem_rsp_vld  = 1'b1;
        #1;
        check_eq("t6_pre_out", outstanding, 3);
        check_eq("t6_pre_rsp_vld", imem_rsp_vld, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_out", outstanding, 0);
        check_eq("t6_rst_vlds", {imem_rsp_vld, dmem_rsp_vld, mem_req_vld}, 3'b000);
        check_eq("t6_rst_rdys", {imem_req_rdy, dmem_req_rdy, mem_rsp_rdy}, 3'b000);
        mem_rsp_vld = 1'b0;
        mem_req_rdy = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        #1;
        check_eq("t6_first_grant_dmem", dmem_req_rdy, 1);
        check_eq("t6_first_grant_imem", imem_req_rdy, 0);
        check_eq("t6_rsp_err_clear", rsp_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
